router_fifo: RTL
================

# router_fifo

Per-output-port packet buffer of the 1x3 router. It sits directly downstream of the router register stage and stores the byte stream that stage drives: header, payload, then parity. Each stored word carries a header-marker bit, so the read side can track packet boundaries from the payload length in the header. Three instances exist, one per destination port. Each is written by the router controller and drained by the destination's read enable.

## Interface
- `DEPTH`, 16: number of entries; must be a power of two.
- `WIDTH`, 8: data byte width; each stored word is WIDTH+1 bits (header marker + byte).
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `soft_reset` input 1: synchronous, active-high flush of this port, issued by the controller on read timeout.
- `write_enb` input 1: write request for the byte on `data_in`.
- `read_enb` input 1: read request from the destination.
- `lfd_state` input 1: marks the current write as a header byte (stored as bit WIDTH).
- `data_in` input WIDTH: byte from the router register stage.
- `data_out` output WIDTH: registered read data.
- `full` output 1: no free entry.
- `empty` output 1: no stored entry.
- `pkt_end` output 1: one-cycle pulse when the final byte of a packet (parity) is read.
- `fifo_err` output 1: present only with `ROUTER_FIFO_ERR_EN`; see Configuration.

## Operation
- Storage is DEPTH x (WIDTH+1). Pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- `full` is asserted when the pointer MSBs differ and the low bits are equal.
- `empty` is asserted when the pointers are equal.
- Both flags are combinational from the registered pointers only.
- **Write:** occurs when `write_enb && !full`. It stores {`lfd_state`, `data_in`} at `wr_ptr`, then `wr_ptr`+1. A write while full is dropped and changes no state.
- **Read:** occurs when `read_enb && !empty`. It loads `data_out` with the low WIDTH bits at `rd_ptr`, then `rd_ptr`+1. A read while empty is dropped, and `data_out` holds its value.
- **Packet counter** (`pkt_cnt`, 7 bits):
  - Read of a word with marker=1: `pkt_cnt` <= `data[7:2]` + 1 (payload length plus parity).
  - Read of a word with marker=0 and `pkt_cnt` != 0: `pkt_cnt` decrements.
  - When that decrement goes from 1 to 0, `pkt_end` pulses and `data_out` is zeroed on the following cycle unless another read occurs in that cycle.
  - Read of a word with marker=0 and `pkt_cnt` = 0: stray byte; data is passed through and the count is unchanged.
- **Simultaneous read and write:**
  - Both proceed when legal.
  - When `full`, only the read proceeds (`full` is evaluated before the edge).
  - When `empty`, only the write proceeds.
- **`soft_reset`:** clears the pointers, `pkt_cnt`, `data_out` and `pkt_end` in that cycle. Memory contents are not cleared but become unreachable. `soft_reset` overrides any read or write in the same cycle.
- **`reset`:** has priority over everything. Values after reset:
  - `data_out`=0, `full`=0, `empty`=1, `pkt_end`=0, `fifo_err`=0.
  - Pointers and `pkt_cnt` = 0.

## Timing
- Write-to-`empty` deassertion: 1 cycle (visible after the write edge).
- Read latency: `data_out` is valid on the edge after `read_enb` is sampled with `!empty`.
- `pkt_end` is registered. It is high in the same cycle that the parity byte appears on `data_out`, and lasts exactly 1 cycle.
- Back-to-back reads stream one byte per cycle with no bubbles.
- A mid-packet `reset` or `soft_reset` abandons the packet. No `pkt_end` is produced for it.

## Configuration
- **`ROUTER_FIFO_ERR_EN` defined:**
  - Adds the `fifo_err` output, a sticky high flag.
  - It is set on the cycle after a write attempt while `full` (and no simultaneous read), or a read attempt while `empty`.
  - It is cleared only by `reset` or `soft_reset`.
- **Not defined:** no `fifo_err` port and no associated logic. Illegal accesses are silently dropped as described in Operation.

## Test plan
- **Basic packet:** after `reset`, write header 0x0D (length 3, marker 1), payload 0x11 0x22 0x33, then parity 0x3F; then read 5 cycles.
  - `data_out` sequence: 0x0D, 0x11, 0x22, 0x33, 0x3F.
  - `pkt_end` is high only with 0x3F; `data_out` is 0x00 one cycle later.
  - `empty` returns to 1.
- **Fill:** 16 writes of 0x00..0x0F with no reads, then a 17th write of 0xAA.
  - `full`=1 after the 16th write; the 17th write is dropped.
  - Reading 16 times returns 0x00..0x0F.
  - With `ROUTER_FIFO_ERR_EN`, `fifo_err`=1.
- **Simultaneous access while full:** with `full`=1, assert `read_enb` and `write_enb` with 0x55.
  - Only the read occurs; `full` drops to 0.
  - The next write of 0x55 is accepted.
- **Empty read:** `read_enb` with `empty`=1 and prior `data_out`=0x3F.
  - `data_out` holds 0x3F; pointers are unchanged.
  - With `ROUTER_FIFO_ERR_EN`, `fifo_err`=1.
- **Wrap-around:** stream 40 bytes with one write and one read per cycle.
  - Output equals input delayed 1 cycle.
  - `full` is never asserted.
- **Soft reset mid-packet:** write header 0x15 plus 2 bytes, read 2 bytes, then pulse `soft_reset`.
  - `empty`=1, `data_out`=0x00, `pkt_end` never pulses.
  - `fifo_err` is cleared.

Source files
------------

// File: rtl/router_fifo_if.sv
// router_fifo_if: write/read handshake bundle between the router controller,
// the destination port and one router_fifo instance.
// The optional fifo_err signal exists only when ROUTER_FIFO_ERR_EN is defined.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_end;
`ifdef ROUTER_FIFO_ERR_EN
  logic             fifo_err;
`endif

  // Controller / destination side
  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
`ifdef ROUTER_FIFO_ERR_EN
    input  fifo_err,
`endif
    input  data_out, full, empty, pkt_end
  );

  // FIFO side
  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
`ifdef ROUTER_FIFO_ERR_EN
    output fifo_err,
`endif
    output data_out, full, empty, pkt_end
  );
endinterface

// File: rtl/router_fifo.sv
// router_fifo: per-output-port packet buffer of the 1x3 router.
// Stores {header marker, byte} words; the read side tracks packet length from
// the header and pulses pkt_end with the parity byte.
// Optional feature macro: ROUTER_FIFO_ERR_EN (adds the sticky fifo_err flag).
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input logic          clock,
  input logic          reset,
  router_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [6:0]       r_pkt_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_pkt_end;

  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;
  logic             w_clear;
  logic [WIDTH:0]   w_rd_word;
  logic             w_rd_marker;
  logic [WIDTH-1:0] w_rd_byte;
  logic [6:0]       w_hdr_len;

  // Flags come only from the registered pointers
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_clear = reset || bus.soft_reset;
  assign w_wr    = bus.write_enb && !w_full;
  assign w_rd    = bus.read_enb && !w_empty;

  assign w_rd_word   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_rd_marker = w_rd_word[WIDTH];
  assign w_rd_byte   = w_rd_word[WIDTH-1:0];
  // Header carries payload length in bits [WIDTH-1:2]; +1 accounts for parity
  assign w_hdr_len   = 7'(w_rd_byte[WIDTH-1:2]) + 7'd1;

  // Storage array: flushed words are not erased, only made unreachable
  always_ff @(posedge clock) begin
    if (w_wr && !w_clear) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  // Write and read pointers, wrapping through the extra MSB
  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Read data, packet length tracking and end-of-packet pulse
  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_data_out <= '0;
      r_pkt_cnt  <= '0;
      r_pkt_end  <= 1'b0;
    end else begin
      r_pkt_end <= 1'b0;
      if (w_rd) begin
        r_data_out <= w_rd_byte;
        if (w_rd_marker) begin
          r_pkt_cnt <= w_hdr_len;
        end else if (r_pkt_cnt != 7'd0) begin
          // A stray byte (count already zero) passes through untouched
          r_pkt_cnt <= r_pkt_cnt - 7'd1;
          if (r_pkt_cnt == 7'd1) r_pkt_end <= 1'b1;
        end
      end else if (r_pkt_end) begin
        // Parity byte is shown for one cycle only when no read follows it
        r_data_out <= '0;
      end
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.pkt_end  = r_pkt_end;

`ifdef ROUTER_FIFO_ERR_EN
  logic r_fifo_err;

  // Sticky flag for dropped accesses; a write while full is not an error
  // when a read frees an entry in the same cycle
  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_fifo_err <= 1'b0;
    end else if ((bus.write_enb && w_full && !bus.read_enb) ||
                 (bus.read_enb && w_empty)) begin
      r_fifo_err <= 1'b1;
    end
  end

  assign bus.fifo_err = r_fifo_err;
`endif
endmodule
